tick_bcd_seg_counter: RTL and testbench
=======================================

Name: tick_bcd_seg_counter

Overview:
- Sits directly downstream of the 0.5 s tick generator and consumes its one-clock `flag` pulse on input `tick`.
- On each enabled tick it advances a 6-digit BCD counter, up or down.
- It time-multiplexes the six digits onto a common-anode 7-segment display, with optional leading-zero blanking.
- It exports the BCD value and a wrap pulse for other logic.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit scan slot (1 ms at 50 MHz). Legal range 2..2^20.
- LZB_EN, 1: 1 blanks leading zeros. Digit 0 (units) is never blanked.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-clk count pulse from the upstream timer.
- en  input  1  1 = ticks are counted, 0 = paused (ticks ignored).
- up_dn  input  1  1 = count up, 0 = count down. Sampled on the tick cycle.
- clr  input  1  synchronous clear of the count.
- count_bcd  output  24  registered BCD value. [3:0] is units, [23:20] is the most significant digit.
- wrap  output  1  one-clk pulse on wrap-around.
- seg_sel  output  6  digit enables, active-low, one-hot-zero. Bit 0 is the units digit.
- seg_led  output  8  segments, active-low. [7] = dp (always 1), [6:0] = g..a.

Behaviour:
- Reset values (async, while rst_n = 0): count_bcd = 0, wrap = 0, seg_sel = 6'b111111, seg_led = 8'hFF, scan counter = 0, digit index = 0.
- Count update priority per clk, highest first:
  1. clr = 1: count_bcd <= 0, wrap <= 0. Overrides a tick in the same cycle.
  2. tick & en & up_dn: BCD increment.
  3. tick & en & !up_dn: BCD decrement.
  4. Otherwise hold, and wrap <= 0.
- Latency: count_bcd and wrap change on the clk edge after tick is sampled high (1 cycle).
- Increment arithmetic:
  - Units digit +1. A digit at 9 becomes 0 and carries into the next digit.
  - 999999 -> 000000 with wrap = 1 for exactly one cycle.
- Decrement arithmetic:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - 000000 -> 999999 with wrap = 1 for exactly one cycle.
- Every digit must remain 0..9 at all times. Non-BCD codes are unreachable.
- tick held high for N consecutive cycles counts N times. No edge detection; upstream guarantees 1-cycle pulses.
- Scan timer:
  - scan_cnt counts 0..SCAN_DIV-1 and then wraps.
  - On the wrap cycle the digit index advances 0->1->...->5->0.
  - The scan runs continuously, independent of en and clr.
- Display output (registered, updated every clk from the current digit index and live count_bcd):
  - seg_sel: the bit for the current digit is 0, all others are 1.
  - seg_led: the active-low decode of that digit's BCD value. 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Display latency: 1 clk after the index or count changes.
- Leading-zero blanking:
  - Applies when LZB_EN = 1 and the selected digit plus every higher digit are all 0, and the selected digit is not the units digit.
  - A blanked digit drives seg_led = FF; seg_sel is still driven low for that slot.
- Reset asserted mid-count or mid-scan: all state returns immediately to reset values. After release the count restarts at 0 and the scan at digit 0.

Test Plan:
- Reset/idle (SCAN_DIV=4): after rst_n release, no tick.
  - count_bcd = 0, wrap = 0.
  - seg_sel sequences 111110, 111101, 111011, ... with 4 clks per slot.
  - seg_led = C0 on digit 0 and FF on digits 1-5.
- Up count with carry: preload to 000009 via 9 ticks, en=1, up_dn=1, then one tick.
  - count_bcd = 24'h000010 one cycle later, wrap = 0.
  - Digit 1 shows F9 and digit 0 shows C0.
- Up wrap: reach 999999, then one tick.
  - count_bcd = 0 and wrap = 1 for exactly 1 clk.
  - A second tick gives 000001 with wrap = 0.
- Down borrow and down wrap:
  - From 000100 a down tick gives 000099.
  - From 000000 a down tick gives 999999 with a 1-clk wrap pulse.
  - All six digits then display 90.
- Pause and clr priority:
  - en=0 with 5 ticks: count unchanged.
  - clr=1 coincident with a tick at 000123: count_bcd = 0 and wrap = 0.
- Async reset mid-operation: assert rst_n=0 at count 004567 in scan slot 3, between clk edges.
  - Outputs go to reset values before the next edge.
  - After release, the scan restarts at digit 0.

Source files
------------

// File: rtl/tick_bcd_seg_counter.sv
// Six-digit BCD up/down tick counter with a time-multiplexed, active-low
// common-anode 7-segment driver and optional leading-zero blanking.
module tick_bcd_seg_counter #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZB_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clr,
  output logic [23:0] count_bcd,
  output logic        wrap,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [23:0]   count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [23:0]   inc_v, dec_v;
  logic          inc_c, dec_b;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_idx_q, dig_idx_d;
  logic [5:0]    seg_sel_q, seg_sel_d;
  logic [7:0]    seg_led_q, seg_led_d;
  logic [23:0]   shifted;
  logic [3:0]    cur_digit;
  logic          blank;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Ripple carry/borrow across digits; a carry out of the top digit is the wrap.
  always_comb begin
    inc_v = count_q;
    dec_v = count_q;
    inc_c = 1'b1;
    dec_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (inc_c) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_v[4*i +: 4] = 4'd9;
        end else begin
          dec_v[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = 24'd0;
    end else if (tick && en) begin
      if (up_dn) begin
        count_d = inc_v;
        wrap_d  = inc_c;
      end else begin
        count_d = dec_v;
        wrap_d  = dec_b;
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
    end
  end

  // The selected digit is blank when it and all digits above it are zero.
  always_comb begin
    shifted   = count_q >> {dig_idx_q, 2'b00};
    cur_digit = shifted[3:0];
    blank     = LZB_EN && (dig_idx_q != 3'd0) && (shifted == 24'd0);
    seg_sel_d = ~(6'b000001 << dig_idx_q);
    seg_led_d = blank ? 8'hFF : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 24'd0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      dig_idx_q  <= 3'd0;
      seg_sel_q  <= 6'b111111;
      seg_led_q  <= 8'hFF;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      seg_sel_q  <= seg_sel_d;
      seg_led_q  <= seg_led_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign seg_sel   = seg_sel_q;
  assign seg_led   = seg_led_q;

endmodule

// File: tb/tb_tick_bcd_seg_counter.sv
// Directed bench for tick_bcd_seg_counter: decimal reference model feeding an
// expected queue, plus scan/segment checks on the multiplexed display.
module tb_tick_bcd_seg_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        clr = 1'b0;
  logic [23:0] count_bcd;
  logic        wrap;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  int checks = 0;
  int failures = 0;
  int model_v = 0;
  logic [24:0] exp_q[$];

  tick_bcd_seg_counter #(.SCAN_DIV(4), .LZB_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .up_dn(up_dn), .clr(clr),
    .count_bcd(count_bcd), .wrap(wrap), .seg_sel(seg_sel), .seg_led(seg_led)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int div;
    r = '0;
    div = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_led(input int k, input int v);
    int d;
    int hi;
    int div;
    div = 1;
    for (int i = 0; i < k; i++) div = div * 10;
    hi = v / div;
    d  = hi % 10;
    if (k > 0 && hi == 0) return 8'hFF;
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  default: return 8'h90;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, push the model's result, compare at the next negedge.
  task automatic cyc(input logic t, input logic e, input logic ud, input logic c);
    logic [24:0] got;
    logic w;
    tick = t; en = e; up_dn = ud; clr = c;
    w = 1'b0;
    if (c) model_v = 0;
    else if (t && e) begin
      if (ud) begin
        if (model_v == 999999) begin model_v = 0; w = 1'b1; end
        else model_v = model_v + 1;
      end else begin
        if (model_v == 0) begin model_v = 999999; w = 1'b1; end
        else model_v = model_v - 1;
      end
    end
    exp_q.push_back({w, to_bcd(model_v)});
    @(negedge clk);
    tick = 1'b0; clr = 1'b0;
    got = exp_q.pop_front();
    chk("count_bcd", 32'(count_bcd), 32'(got[23:0]));
    chk("wrap", 32'(wrap), 32'(got[24]));
  endtask

  task automatic run(input int n, input logic ud);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, ud, 1'b0);
  endtask

  task automatic check_digit(input int k);
    logic [5:0] sel;
    int n;
    sel = ~(6'b000001 << k);
    n = 0;
    while (seg_sel !== sel && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("digit_found", 32'(seg_sel), 32'(sel));
    chk("seg_led", 32'(seg_led), 32'(exp_led(k, model_v)));
  endtask

  task automatic check_scan_from_zero(input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      chk("scan_sel", 32'(seg_sel), 32'(~(6'b000001 << (((c - 1) / 4) % 6)) & 6'h3F));
      chk("scan_led", 32'(seg_led), 32'(exp_led(((c - 1) / 4) % 6, model_v)));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count_bcd), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_sel", 32'(seg_sel), 32'h3F);
    chk("rst_led", 32'(seg_led), 32'hFF);
    rst_n = 1'b1;
    check_scan_from_zero(26);

    run(9, 1'b1);
    run(1, 1'b1);
    chk("carry_value", 32'(count_bcd), 32'h000010);
    check_digit(1);
    check_digit(0);
    check_digit(2);

    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    run(1, 1'b0);
    chk("down_wrap_value", 32'(count_bcd), 32'h999999);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) check_digit(k);

    run(1, 1'b1);
    chk("up_wrap_value", 32'(count_bcd), 32'h000000);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    run(1, 1'b1);

    run(99, 1'b1);
    run(1, 1'b0);
    chk("borrow_value", 32'(count_bcd), 32'h000099);

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    run(24, 1'b1);
    chk("pre_clr_value", 32'(count_bcd), 32'h000123);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);

    run(4567, 1'b1);
    chk("pre_reset_value", 32'(count_bcd), 32'h004567);
    check_digit(3);
    #2 rst_n = 1'b0;
    #1;
    model_v = 0;
    chk("async_count", 32'(count_bcd), 32'h0);
    chk("async_wrap", 32'(wrap), 32'h0);
    chk("async_sel", 32'(seg_sel), 32'h3F);
    chk("async_led", 32'(seg_led), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_scan_from_zero(10);
    run(2, 1'b1);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
